// File: rtl/mdu.sv
// mdu: multiply/divide unit for the EX stage.
//   Holds the architectural HI/LO registers. mult/multu/div/divu compute their
//   full result on the start edge into temporary registers. The temporary
//   result is committed to HI/LO after a fixed Busy period. mthi/mtlo write HI/LO
//   directly. mfhi/mflo are read combinationally through MDUOut.
//
// Ports:
//   clk, reset    rising-edge clock, async active-high reset
//   Start, MDUOp  MDU instruction present in EX and its opcode
//   A, B          forwarded rs / rt operands
//   Busy          multi-cycle operation in flight
//   HI, LO        architectural HI / LO
//   MDUOut        HI for mfhi, LO for mflo, else 0
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | accepting ops; mthi/mtlo complete here
// BUSY  | mult/div latency countdown, result held in temp

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   temp_hi_q, temp_hi_d;
  logic [31:0]   temp_lo_q, temp_lo_d;
  logic          commit_q, commit_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_b;
  logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes so the overflow case (0x80000000 / -1) falls
  // out naturally: |dividend| = 0x80000000 and the quotient sign is positive.
  // A zero divisor is replaced by 1 only to keep the divider defined; that
  // result is never committed.
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign div_b   = (B == 32'd0) ? 32'd1 : b_mag;
  assign quo_mag = a_mag / div_b;
  assign rem_mag = a_mag % div_b;
  assign quo_s   = (A[31] ^ B[31]) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s   = A[31] ? (~rem_mag + 32'd1) : rem_mag;
  assign quo_u   = A / ((B == 32'd0) ? 32'd1 : B);
  assign rem_u   = A % ((B == 32'd0) ? 32'd1 : B);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    commit_d  = commit_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            4'd1: begin
              {temp_hi_d, temp_lo_d} = prod_s;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = BUSY;
            end
            4'd2: begin
              {temp_hi_d, temp_lo_d} = prod_u;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = BUSY;
            end
            4'd3: begin
              temp_hi_d = rem_s;
              temp_lo_d = quo_s;
              cnt_d     = CW'(DIV_CYCLES);
              commit_d  = (B != 32'd0);
              state_d   = BUSY;
            end
            4'd4: begin
              temp_hi_d = rem_u;
              temp_lo_d = quo_u;
              cnt_d     = CW'(DIV_CYCLES);
              commit_d  = (B != 32'd0);
              state_d   = BUSY;
            end
            4'd7:    hi_d = A;
            4'd8:    lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (commit_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      commit_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      commit_q  <= commit_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == 4'd5)      MDUOut = hi_q;
    else if (MDUOp == 4'd6) MDUOut = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Multi-cycle ops come from a vector
// table; expected HI/LO are pushed to a scoreboard queue at issue and popped
// when Busy falls. Reset, mthi/mtlo, divide-by-zero, ignored Start and
// reset-during-op are exercised by hand-written sequences.

module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;
  vec_t vecs[9];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Single-cycle op (mthi/mtlo or a no-effect op) issued in IDLE.
  task automatic issue1(input logic st, input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    Start = st; MDUOp = op; A = a; B = 32'h0;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0; A = 32'h0;
    if (st && op == 4'd7) m_hi = a;
    if (st && op == 4'd8) m_lo = a;
    check("single_busy", {31'd0, Busy}, 32'd0);
    check("single_hi", HI, m_hi);
    check("single_lo", LO, m_lo);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ncyc,
                        input bit inject);
    int   cyc;
    exp_t e;
    e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0; A = 32'h0; B = 32'h0;
    cyc = 0;
    while (Busy && cyc < 200) begin
      cyc++;
      check("hold_hi", HI, m_hi);
      check("hold_lo", LO, m_lo);
      if (inject && cyc == 3) begin
        Start = 1'b1; MDUOp = 4'd8; A = 32'h1;
      end
      @(negedge clk);
      Start = 1'b0; MDUOp = 4'd0; A = 32'h0;
    end
    check("busy_len", cyc, ncyc);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("result_hi", HI, e.hi);
      check("result_lo", LO, e.lo);
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[5] = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[6] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[8] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};

    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = 32'h0; B = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    #22 reset = 1'b0;

    // Load nonzero HI/LO, then reset between clock edges.
    issue1(1'b1, 4'd7, 32'hDEAD0001);
    issue1(1'b1, 4'd8, 32'hBEEF0002);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hi", HI, 32'h0);
    check("async_rst_lo", LO, 32'h0);
    check("async_rst_busy", {31'd0, Busy}, 32'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b0;

    issue1(1'b1, 4'd7, 32'h12345678);
    MDUOp = 4'd5; #1;
    check("mfhi", MDUOut, 32'h12345678);
    MDUOp = 4'd6; #1;
    check("mflo", MDUOut, 32'h0);
    MDUOp = 4'd2; #1;
    check("mduout_other", MDUOut, 32'h0);
    MDUOp = 4'd0;

    // No-effect cases: bad opcode with Start, valid opcode without Start.
    issue1(1'b1, 4'd9, 32'h55555555);
    issue1(1'b1, 4'd0, 32'h55555555);
    issue1(1'b0, 4'd7, 32'h66666666);
    issue1(1'b0, 4'd1, 32'h66666666);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0);
      MDUOp = 4'd5; #1;
      check("vec_mfhi", MDUOut, vecs[i].hi);
      MDUOp = 4'd6; #1;
      check("vec_mflo", MDUOut, vecs[i].lo);
      MDUOp = 4'd0;
    end

    // Divide by zero keeps HI/LO.
    issue1(1'b1, 4'd7, 32'hAAAA0000);
    issue1(1'b1, 4'd8, 32'h0000BBBB);
    run_op(4'd4, 32'h7, 32'h0, 32'hAAAA0000, 32'h0000BBBB, 10, 1'b0);
    run_op(4'd3, 32'h7, 32'h0, 32'hAAAA0000, 32'h0000BBBB, 10, 1'b0);

    // mtlo during cycle 3 of a mult is ignored.
    run_op(4'd1, 32'h3, 32'h4, 32'h0, 32'hC, 5, 1'b1);

    // Reset during cycle 4 of a div discards it.
    issue1(1'b1, 4'd7, 32'h0BAD0BAD);
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'd4; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0; A = 32'h0; B = 32'h0;
    cyc = 1;
    while (Busy && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midop_rst_busy", {31'd0, Busy}, 32'd0);
    check("midop_rst_hi", HI, 32'h0);
    check("midop_rst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    check("post_rst_hi", HI, 32'h0);
    check("post_rst_lo", LO, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
